// File: rtl/note_lane_sequencer.sv
// Chart-driven five-lane falling-note sequencer: one chart entry per beat, notes advance per frame.
// Optional build macro SPEED_RAMP_EN: speed ramps by 1 every 16 spawns (saturating at 15).
module note_lane_sequencer #(
    parameter int unsigned Y_START     = 0,
    parameter int unsigned Y_END       = 479,
    parameter int unsigned PARK_Y      = 1023,
    parameter int unsigned SPEED       = 4,
    parameter int unsigned BEAT_FRAMES = 16,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_tick,
    input  logic              start,
    input  logic              pause,
    output logic [ADDR_W-1:0] chart_addr,
    input  logic [7:0]        chart_data,
    output logic [9:0]        green_y_pos,
    output logic [9:0]        red_y_pos,
    output logic [9:0]        yellow_y_pos,
    output logic [9:0]        blue_y_pos,
    output logic [9:0]        orange_y_pos,
    output logic [4:0]        lane_active,
    output logic              beat_pulse,
    output logic              song_done
);

    localparam int unsigned   FC_W    = $clog2(BEAT_FRAMES);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BEAT_FRAMES - 1);
    localparam logic [9:0]    PARK    = 10'(PARK_Y);
    localparam logic [9:0]    SPAWN_Y = 10'(Y_START);
    localparam logic [10:0]   Y_LIMIT = 11'(Y_END);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_SPAWN,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    logic [9:0]      lane_y    [5];
    logic [9:0]      moved_y   [5];
    logic [10:0]     next_y    [5];
    logic [4:0]      moved_act;
    logic [FC_W-1:0] frame_cnt;
    logic [3:0]      speed;
    logic            accept_tick;
    logic            unused_data_bits;

    assign unused_data_bits = &{1'b0, chart_data[6:5]};
    assign accept_tick      = frame_tick & ~pause;

    assign green_y_pos  = lane_y[0];
    assign red_y_pos    = lane_y[1];
    assign yellow_y_pos = lane_y[2];
    assign blue_y_pos   = lane_y[3];
    assign orange_y_pos = lane_y[4];

`ifdef SPEED_RAMP_EN
    logic [3:0] speed_q;
    logic [3:0] spawn_cnt;

    assign speed = speed_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            speed_q   <= 4'(SPEED);
            spawn_cnt <= '0;
        end else begin
            if ((state == S_IDLE || state == S_DONE) && start) begin
                speed_q   <= 4'(SPEED);
                spawn_cnt <= '0;
            end else if (state == S_SPAWN) begin
                spawn_cnt <= spawn_cnt + 4'd1;
                if (spawn_cnt == 4'd15 && speed_q != 4'd15)
                    speed_q <= speed_q + 4'd1;
            end
        end
    end
`else
    assign speed = 4'(SPEED);
`endif

    // Per-frame movement of every lane; retiring lanes park immediately.
    always_comb begin
        for (int unsigned l = 0; l < 5; l++) begin
            next_y[l]    = {1'b0, lane_y[l]} + 11'(speed);
            moved_y[l]   = lane_y[l];
            moved_act[l] = lane_active[l];
            if (lane_active[l]) begin
                if (next_y[l] > Y_LIMIT) begin
                    moved_y[l]   = PARK;
                    moved_act[l] = 1'b0;
                end else begin
                    moved_y[l] = next_y[l][9:0];
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            chart_addr  <= '0;
            frame_cnt   <= '0;
            lane_active <= '0;
            beat_pulse  <= 1'b0;
            song_done   <= 1'b0;
            for (int unsigned l = 0; l < 5; l++)
                lane_y[l] <= PARK;
        end else begin
            beat_pulse <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        chart_addr  <= '0;
                        frame_cnt   <= '0;
                        lane_active <= '0;
                        song_done   <= 1'b0;
                        for (int unsigned l = 0; l < 5; l++)
                            lane_y[l] <= PARK;
                        state <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    beat_pulse <= 1'b1;
                    state      <= S_SPAWN;
                end
                S_SPAWN: begin
                    if (chart_data[7]) begin
                        state <= S_DRAIN;
                    end else begin
                        for (int unsigned l = 0; l < 5; l++) begin
                            if (chart_data[l] && !lane_active[l]) begin
                                lane_y[l]      <= SPAWN_Y;
                                lane_active[l] <= 1'b1;
                            end
                        end
                        // The last ROM address ends the chart rather than wrapping.
                        if (chart_addr == '1) begin
                            state <= S_DRAIN;
                        end else begin
                            chart_addr <= chart_addr + 1'b1;
                            state      <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (accept_tick) begin
                        lane_y      <= moved_y;
                        lane_active <= moved_act;
                        if (frame_cnt == FC_LAST) begin
                            frame_cnt  <= '0;
                            beat_pulse <= 1'b1;
                            state      <= S_SPAWN;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (lane_active == '0) begin
                        song_done <= 1'b1;
                        state     <= S_DONE;
                    end else if (accept_tick) begin
                        lane_y      <= moved_y;
                        lane_active <= moved_act;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_lane_sequencer.sv
// Randomised bench for note_lane_sequencer against a tick-level lane model.
// Honours SPEED_RAMP_EN in the model when the macro is defined for the build.
module tb_note_lane_sequencer;

    localparam int unsigned Y_START     = 0;
    localparam int unsigned Y_END       = 479;
    localparam int unsigned PARK_Y      = 1023;
    localparam int unsigned SPEED       = 4;
    localparam int unsigned BEAT_FRAMES = 16;
    localparam int unsigned ADDR_W      = 8;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              frame_tick = 1'b0;
    logic              start = 1'b0;
    logic              pause = 1'b0;
    logic [ADDR_W-1:0] chart_addr;
    logic [7:0]        chart_data;
    logic [9:0]        green_y_pos, red_y_pos, yellow_y_pos, blue_y_pos, orange_y_pos;
    logic [4:0]        lane_active;
    logic              beat_pulse;
    logic              song_done;

    note_lane_sequencer #(
        .Y_START(Y_START),
        .Y_END(Y_END),
        .PARK_Y(PARK_Y),
        .SPEED(SPEED),
        .BEAT_FRAMES(BEAT_FRAMES),
        .ADDR_W(ADDR_W)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .frame_tick(frame_tick),
        .start(start),
        .pause(pause),
        .chart_addr(chart_addr),
        .chart_data(chart_data),
        .green_y_pos(green_y_pos),
        .red_y_pos(red_y_pos),
        .yellow_y_pos(yellow_y_pos),
        .blue_y_pos(blue_y_pos),
        .orange_y_pos(orange_y_pos),
        .lane_active(lane_active),
        .beat_pulse(beat_pulse),
        .song_done(song_done)
    );

    always #10 Clk = ~Clk;

    logic [7:0] rom [256];
    always @(posedge Clk) chart_data <= rom[chart_addr];

    logic [9:0] dut_y [5];
    assign dut_y[0] = green_y_pos;
    assign dut_y[1] = red_y_pos;
    assign dut_y[2] = yellow_y_pos;
    assign dut_y[3] = blue_y_pos;
    assign dut_y[4] = orange_y_pos;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: positions per lane, advanced per accepted frame.
    int m_y [5];
    bit m_act [5];
    int m_addr, m_tick, m_speed, m_spawns;
    bit m_drain, m_live, m_done;

    function automatic logic [4:0] m_mask();
        logic [4:0] m;
        for (int l = 0; l < 5; l++) m[l] = m_act[l];
        return m;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < 5; l++) begin
            m_y[l]   = PARK_Y;
            m_act[l] = 0;
        end
        m_addr = 0; m_tick = 0; m_drain = 0; m_live = 0; m_done = 0;
        m_speed = SPEED; m_spawns = 0;
    endtask

    task automatic model_start();
        model_reset();
        m_live = 1;
    endtask

    task automatic model_move(output bit beat);
        int n;
        beat = 0;
        for (int l = 0; l < 5; l++) begin
            if (m_act[l]) begin
                n = m_y[l] + m_speed;
                if (n > Y_END) begin
                    m_act[l] = 0;
                    m_y[l]   = PARK_Y;
                end else begin
                    m_y[l] = n;
                end
            end
        end
        if (!m_drain) begin
            m_tick++;
            if (m_tick == BEAT_FRAMES) begin
                m_tick = 0;
                beat   = 1;
            end
        end
    endtask

    task automatic model_spawn();
        logic [7:0] d;
        d = rom[m_addr];
        m_spawns++;
`ifdef SPEED_RAMP_EN
        if (m_spawns % 16 == 0 && m_speed < 15) m_speed++;
`endif
        if (d[7]) begin
            m_drain = 1;
        end else begin
            for (int l = 0; l < 5; l++) begin
                if (d[l] && !m_act[l]) begin
                    m_act[l] = 1;
                    m_y[l]   = Y_START;
                end
            end
            if (m_addr == 255) m_drain = 1;
            else m_addr++;
        end
    endtask

    task automatic check_lanes(input string tag);
        for (int l = 0; l < 5; l++)
            check_value($sformatf("%s_y%0d", tag, l), 32'(dut_y[l]), 32'(m_y[l]));
        check_value({tag, "_active"}, 32'(lane_active), 32'(m_mask()));
    endtask

    // Entered at a falling edge; pulses one frame tick and checks the result.
    task automatic do_tick(input bit paused);
        bit beat;
        frame_tick = 1'b1;
        pause      = paused;
        @(negedge Clk);
        frame_tick = 1'b0;
        beat = 0;
        if (!paused && m_live) model_move(beat);
        check_lanes("tick");
        check_value("beat_pulse", 32'(beat_pulse), 32'(beat));
        check_value("song_done_tick", 32'(song_done), 32'(m_done));
        if (beat) begin
            @(negedge Clk);
            model_spawn();
            check_lanes("spawn");
            check_value("beat_pulse_clr", 32'(beat_pulse), 0);
            check_value("chart_addr", 32'(chart_addr), 32'(m_addr));
        end
    endtask

    // Plays the loaded chart; abort_at>=0 hits async reset after that many ticks.
    task automatic run_song(input int pause_at, input int abort_at);
        int  accepted;
        bit  finished, p;
        int  burst_at;
        burst_at = pause_at;
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
        model_start();
        check_lanes("prime");
        check_value("prime_done", 32'(song_done), 0);
        check_value("prime_addr", 32'(chart_addr), 0);
        @(negedge Clk);
        check_value("first_beat", 32'(beat_pulse), 1);
        @(negedge Clk);
        model_spawn();
        check_lanes("spawn0");
        check_value("addr0", 32'(chart_addr), 32'(m_addr));
        accepted = 0;
        finished = 0;
        for (int it = 0; it < 20000; it++) begin
            if (m_drain && m_mask() == 0) begin
                @(negedge Clk);
                m_live = 0;
                m_done = 1;
                check_value("song_done", 32'(song_done), 1);
                finished = 1;
                break;
            end
            if ($urandom_range(0, 19) == 0) begin
                start = 1'b1;
                @(negedge Clk);
                start = 1'b0;
            end else begin
                @(negedge Clk);
            end
            if ($urandom_range(0, 1) == 1) @(negedge Clk);
            if (accepted == abort_at) begin
                #3 Reset_n = 1'b0;
                #1;
                model_reset();
                check_lanes("async_rst");
                check_value("async_rst_addr", 32'(chart_addr), 0);
                check_value("async_rst_beat", 32'(beat_pulse), 0);
                check_value("async_rst_done", 32'(song_done), 0);
                @(negedge Clk);
                Reset_n = 1'b1;
                return;
            end
            if (accepted == burst_at) begin
                burst_at = -1;
                repeat (10) begin
                    do_tick(1'b1);
                    @(negedge Clk);
                end
            end
            p = ($urandom_range(0, 9) == 0);
            do_tick(p);
            pause = 1'b0;
            if (!p) accepted++;
        end
        if (!finished) check_value("song_timeout", 0, 1);
        @(negedge Clk);
        do_tick(1'b0);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int len;
        clear_rom();
        model_reset();
        repeat (3) @(negedge Clk);
        check_lanes("reset");
        check_value("reset_addr", 32'(chart_addr), 0);
        check_value("reset_beat", 32'(beat_pulse), 0);
        check_value("reset_done", 32'(song_done), 0);
        Reset_n = 1'b1;

        // Single green note, pause burst at green_y=40.
        rom[0] = 8'h01; rom[1] = 8'h80;
        run_song(10, -1);

        // Second green note dropped while the first is still falling.
        clear_rom();
        rom[0] = 8'h01; rom[1] = 8'h01; rom[2] = 8'h80;
        run_song(-1, -1);

        // All five lanes together.
        clear_rom();
        rom[0] = 8'h1F; rom[1] = 8'h80;
        run_song(-1, -1);

        // Async reset mid-song, then replay the same chart from address 0.
        clear_rom();
        rom[0] = 8'h03; rom[1] = 8'h14; rom[2] = 8'h68; rom[3] = 8'h80;
        run_song(-1, 20);
        run_song(-1, -1);

        // Random charts; end markers carry random low bits.
        repeat (5) begin
            clear_rom();
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) rom[i] = 8'($urandom_range(0, 127));
            rom[len] = 8'h80 | 8'($urandom_range(0, 127));
            run_song(-1, -1);
        end

        // Full-depth chart without an end marker: stops at the last address.
        clear_rom();
        for (int i = 0; i < 256; i++)
            rom[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 127)) : 8'h00;
        run_song(-1, -1);
        check_value("last_addr", 32'(chart_addr), 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
